// File: rtl/framed_shift_engine_pkg.sv
// Shared types and constants for the framed shift engine: state encoding, shift-order modes,
// and the bit-counter width helper.
package framed_shift_engine_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_SHIFT = 2'd1,
        STATE_DONE  = 2'd2
    } state_e;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/framed_shift_engine_if.sv
// Control/data bus between the SPI edge detector / FSM side (master) and the shift engine (slave).
interface framed_shift_engine_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNTW = framed_shift_engine_pkg::cnt_width(WIDTH);

    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic             frameStart;
    logic             lsbFirst;
    logic [CNTW-1:0]  frameLen;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
    logic             busy;
    logic             frameDone;
    logic             frameAbort;
    logic [CNTW-1:0]  bitCount;

    modport master (
        output peripheralClkEdge, parallelLoad, frameStart, lsbFirst, frameLen,
               parallelDataIn, serialDataIn,
        input  parallelDataOut, serialDataOut, busy, frameDone, frameAbort, bitCount
    );

    modport slave (
        input  peripheralClkEdge, parallelLoad, frameStart, lsbFirst, frameLen,
               parallelDataIn, serialDataIn,
        output parallelDataOut, serialDataOut, busy, frameDone, frameAbort, bitCount
    );

endinterface

// File: rtl/sync2_stage.sv
// Parametrised-width two-flop synchronizer with synchronous active-low clear.
module sync2_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/framed_shift_engine.sv
// WIDTH-bit framed shift register with MSB/LSB-first order, programmable frame length and
// done/abort pulses. Define SHIFT_SYNC_EN to pass the strobe and serial input through sync2_stage.
module framed_shift_engine
    import framed_shift_engine_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rstN,
    framed_shift_engine_if.slave bus
);

    localparam int unsigned CNTW = cnt_width(WIDTH);

    logic edge_s;
    logic sdi_s;

`ifdef SHIFT_SYNC_EN
    logic [1:0] sync_out;

    sync2_stage #(.W(2)) u_sync (
        .clk  (clk),
        .rstN (rstN),
        .d_i  ({bus.peripheralClkEdge, bus.serialDataIn}),
        .q_o  (sync_out)
    );

    assign edge_s = sync_out[1];
    assign sdi_s  = sync_out[0];
`else
    assign edge_s = bus.peripheralClkEdge;
    assign sdi_s  = bus.serialDataIn;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             mode_q, mode_d;
    logic [CNTW-1:0]  len_q, len_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             abort_d;
    logic             sout_q, busy_q, done_q, abort_q;
    logic [CNTW-1:0]  len_clamped;

    // Zero or oversize frame lengths mean a full-width frame.
    assign len_clamped = (bus.frameLen == '0 || bus.frameLen > CNTW'(WIDTH))
                         ? CNTW'(WIDTH) : bus.frameLen;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            STATE_SHIFT: begin
                // A reload always beats a coincident strobe; that strobe is dropped.
                if (bus.parallelLoad) begin
                    data_d  = bus.parallelDataIn;
                    mode_d  = bus.lsbFirst ? MODE_LSB : MODE_MSB;
                    len_d   = len_clamped;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (edge_s) begin
                    data_d = (mode_q == MODE_LSB) ? {sdi_s, data_q[WIDTH-1:1]}
                                                  : {data_q[WIDTH-2:0], sdi_s};
                    cnt_d  = cnt_q + CNTW'(1);
                    if (cnt_q == len_q - CNTW'(1)) begin
                        state_d = STATE_DONE;
                    end
                end
            end
            default: begin
                if (bus.parallelLoad || bus.frameStart) begin
                    if (bus.parallelLoad) begin
                        data_d = bus.parallelDataIn;
                    end
                    mode_d  = bus.lsbFirst ? MODE_LSB : MODE_MSB;
                    len_d   = len_clamped;
                    cnt_d   = '0;
                    state_d = STATE_SHIFT;
                end else begin
                    state_d = STATE_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= STATE_IDLE;
            data_q  <= RESET_VALUE;
            mode_q  <= MODE_MSB;
            len_q   <= CNTW'(WIDTH);
            cnt_q   <= '0;
            sout_q  <= RESET_VALUE[WIDTH-1];
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sout_q  <= (mode_d == MODE_LSB) ? data_d[0] : data_d[WIDTH-1];
            busy_q  <= (state_d == STATE_SHIFT);
            done_q  <= (state_d == STATE_DONE);
            abort_q <= abort_d;
        end
    end

    assign bus.parallelDataOut = data_q;
    assign bus.serialDataOut   = sout_q;
    assign bus.busy            = busy_q;
    assign bus.frameDone       = done_q;
    assign bus.frameAbort      = abort_q;
    assign bus.bitCount        = cnt_q;

endmodule
